// File: rtl/alu_mdu_exec.sv
// Execute stage with a 32-bit single-cycle ALU and an iterative multiply/divide unit.
// The multiply/divide unit takes 32 shift steps plus one sign-fix cycle and writes HI/LO.
module alu_mdu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    localparam logic [3:0] OP_SLL  = 4'd0,  OP_SRL  = 4'd1,  OP_SRA  = 4'd2,  OP_MULT = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd5,  OP_DIVU = 4'd6,  OP_ADD  = 4'd7,  OP_ADDU = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9,  OP_SUBU = 4'd10, OP_AND  = 4'd11, OP_OR   = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13, OP_SLT  = 4'd14, OP_SLTU = 4'd15;

    state_t      r_state, w_state_nx;
    logic [4:0]  r_count;
    logic [31:0] r_result, r_hi, r_lo, r_acc_hi, r_acc_lo, r_opb;
    logic        r_overflow, r_busy, r_done, r_is_div, r_neg_main, r_neg_rem, r_dvz;

    logic        w_is_md, w_is_signed, w_alu_ovf;
    logic [31:0] w_alu_res, w_sum, w_diff, w_abs_a, w_abs_b;
    logic [32:0] w_mul_sum, w_div_shift, w_div_diff;
    logic [63:0] w_prod, w_prod_fix;
    logic [31:0] w_quo_fix, w_rem_fix;

    assign w_is_md     = (aluop >= OP_MULT) && (aluop <= OP_DIVU);
    assign w_is_signed = (aluop == OP_MULT) || (aluop == OP_DIV);
    assign w_abs_a     = (w_is_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b     = (w_is_signed && b[31]) ? (32'd0 - b) : b;
    assign w_sum       = a + b;
    assign w_diff      = a - b;

    // Single-cycle ALU result and signed-overflow flag
    always_comb begin
        w_alu_res = 32'd0;
        w_alu_ovf = 1'b0;
        case (aluop)
            OP_SLL:  w_alu_res = b << a[4:0];
            OP_SRL:  w_alu_res = b >> a[4:0];
            OP_SRA:  w_alu_res = $unsigned($signed(b) >>> a[4:0]);
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            OP_ADDU: w_alu_res = w_sum;
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);
            end
            OP_SUBU: w_alu_res = w_diff;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_SLT:  w_alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: w_alu_res = (a < b) ? 32'd1 : 32'd0;
            default: w_alu_res = 32'd0;
        endcase
    end

    // One iteration step: acc_hi is the partial product / partial remainder,
    // acc_lo holds the remaining multiplier bits / the developing quotient.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : 33'd0);
    assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};

    // With a zero divisor the remainder ends as |a|, so restoring the dividend sign yields a itself.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_main ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = r_dvz ? 32'hFFFF_FFFF : (r_neg_main ? (32'd0 - r_acc_lo) : r_acc_lo);
    assign w_rem_fix  = r_neg_rem ? (32'd0 - r_acc_hi) : r_acc_hi;

    // Next-state logic for the multiply/divide sequencer
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_md) w_state_nx = S_RUN;
                else                  w_state_nx = S_IDLE;
            end
            S_RUN: begin
                if (r_count == 5'd31) w_state_nx = S_FIX;
                else                  w_state_nx = S_RUN;
            end
            S_FIX:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Datapath registers: ALU outputs, iteration state and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= 5'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
            r_opb      <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dvz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_is_md) begin
                        r_busy     <= 1'b1;
                        r_count    <= 5'd0;
                        r_acc_hi   <= 32'd0;
                        r_acc_lo   <= w_abs_a;
                        r_opb      <= w_abs_b;
                        r_is_div   <= (aluop >= OP_DIV);
                        r_neg_main <= w_is_signed && (a[31] ^ b[31]);
                        r_neg_rem  <= w_is_signed && a[31];
                        r_dvz      <= (aluop >= OP_DIV) && (b == 32'd0);
                    end else if (start) begin
                        r_result   <= w_alu_res;
                        r_overflow <= w_alu_ovf;
                        r_done     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 5'd1;
                    if (!r_is_div) begin
                        r_acc_hi <= w_mul_sum[32:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
                    end else if (!w_div_diff[32]) begin
                        r_acc_hi <= w_div_diff[31:0];
                        r_acc_lo <= {r_acc_lo[30:0], 1'b1};
                    end else begin
                        r_acc_hi <= w_div_shift[31:0];
                        r_acc_lo <= {r_acc_lo[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;
    assign zero     = (r_result == 32'd0);
    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule
